// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, access size codes,
// FSM state encoding and packed layouts of the EX->MEM, MEM->WB and forwarding buses.
package mem_stage_pkg;

  localparam int unsigned EX_BUS_W  = 107;
  localparam int unsigned WB_BUS_W  = 70;
  localparam int unsigned FWD_BUS_W = 39;

  // Access size codes carried in mem_op.size
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } mem_state_e;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       is_unsigned;
    logic [1:0] size;
  } mem_op_t;

  typedef struct packed {
    mem_op_t     mem_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] st_data;
    logic [31:0] pc;
  } ex_bus_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } wb_bus_t;

  typedef struct packed {
    logic        fwd_we;
    logic        fwd_load_busy;
    logic [4:0]  dest;
    logic [31:0] result;
  } fwd_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the byte/half lane addressed by addr_lo out of the
// word-aligned SRAM data and zero- or sign-extends it to 32 bits.
// Ports: rdata (word lane), addr_lo (byte offset), size (B/H/W code),
//        is_unsigned (zero-extend), load_data_c (combinational result).
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        ext_bit;

  always_comb begin
    byte_lane   = rdata[7:0];
    half_lane   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ext_bit     = 1'b0;
    load_data_c = rdata;
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    case (size)
      SIZE_B: begin
        ext_bit     = byte_lane[7] & ~is_unsigned;
        load_data_c = {{24{ext_bit}}, byte_lane};
      end
      SIZE_H: begin
        ext_bit     = half_lane[15] & ~is_unsigned;
        load_data_c = {{16{ext_bit}}, half_lane};
      end
      default: load_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: holds one EX result, performs at most one
// data SRAM access per instruction (req/addr_ok/data_ok), aligns load data and
// presents the MEM->WB bus plus a forwarding/hazard bus back to ID.
// Ports: clk/reset (sync, active-high); ex_to_mem_valid/ex_reg/mem_allowin (EX link);
//        wb_allowin/mem_to_wb_valid/mem_reg (WB link); mem_fwd (ID bypass);
//        data_sram_* (SRAM request/response).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_to_mem_valid,
  input  logic [EX_BUS_W-1:0]  ex_reg,
  output logic                 mem_allowin,
  input  logic                 wb_allowin,
  output logic                 mem_to_wb_valid,
  output logic [WB_BUS_W-1:0]  mem_reg,
  output logic [FWD_BUS_W-1:0] mem_fwd,
  output logic                 data_sram_req,
  output logic                 data_sram_wr,
  output logic [1:0]           data_sram_size,
  output logic [3:0]           data_sram_wstrb,
  output logic [31:0]          data_sram_addr,
  output logic [31:0]          data_sram_wdata,
  input  logic                 data_sram_addr_ok,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata
);

  logic       mem_valid_q, mem_valid_d;
  ex_bus_t    ex_reg_q, ex_reg_d;
  mem_state_e state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  ex_bus_t    ex_in;
  wb_bus_t    wb_bus;
  fwd_bus_t   fwd_bus;
  logic       is_mem_op;
  logic       data_ok_hit;
  logic       mem_ready_go;
  logic [1:0] addr_lo;
  logic [31:0] load_src;
  logic [31:0] load_data_c;
  logic [31:0] final_result;

  assign ex_in        = ex_reg;
  assign is_mem_op    = ex_reg_q.mem_op.is_load | ex_reg_q.mem_op.is_store;
  assign addr_lo      = ex_reg_q.alu_result[1:0];
  // data_ok is only meaningful once the request has been accepted
  assign data_ok_hit  = (state_q == ST_WAIT) && data_sram_data_ok;
  assign mem_ready_go = !is_mem_op || (state_q == ST_DONE) || data_ok_hit;

  assign mem_allowin     = !mem_valid_q || (mem_ready_go && wb_allowin);
  assign mem_to_wb_valid = mem_valid_q && mem_ready_go;

  // Next-state: load a new instruction when the slot frees up, else advance the access FSM
  always_comb begin
    mem_valid_d = mem_valid_q;
    ex_reg_d    = ex_reg_q;
    state_d     = state_q;
    rdata_d     = rdata_q;
    if (data_ok_hit) begin
      rdata_d = data_sram_rdata;
    end
    if (mem_allowin) begin
      mem_valid_d = ex_to_mem_valid;
      state_d     = ST_IDLE;
      if (ex_to_mem_valid) begin
        ex_reg_d = ex_in;
        if (ex_in.mem_op.is_load || ex_in.mem_op.is_store) begin
          state_d = ST_REQ;
        end
      end
    end else begin
      case (state_q)
        ST_REQ:  if (data_sram_addr_ok) state_d = ST_WAIT;
        ST_WAIT: if (data_sram_data_ok) state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      ex_reg_q    <= '0;
      state_q     <= ST_IDLE;
      rdata_q     <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      ex_reg_q    <= ex_reg_d;
      state_q     <= state_d;
      rdata_q     <= rdata_d;
    end
  end

  // SRAM request: REQ state implies a valid memory op; addr/wr/size are held by ex_reg_q
  assign data_sram_req  = mem_valid_q && (state_q == ST_REQ);
  assign data_sram_wr   = ex_reg_q.mem_op.is_store;
  assign data_sram_size = ex_reg_q.mem_op.size;
  assign data_sram_addr = ex_reg_q.alu_result;

  // Store lane replication and byte enables
  always_comb begin
    data_sram_wdata = ex_reg_q.st_data;
    data_sram_wstrb = 4'b0000;
    case (ex_reg_q.mem_op.size)
      SIZE_B: begin
        data_sram_wdata = {4{ex_reg_q.st_data[7:0]}};
        data_sram_wstrb = 4'b0001 << addr_lo;
      end
      SIZE_H: begin
        data_sram_wdata = {2{ex_reg_q.st_data[15:0]}};
        data_sram_wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        data_sram_wdata = ex_reg_q.st_data;
        data_sram_wstrb = 4'b1111;
      end
    endcase
    if (!ex_reg_q.mem_op.is_store) begin
      data_sram_wstrb = 4'b0000;
    end
  end

  // Use live rdata in the data_ok cycle, the captured copy while stalled afterwards
  assign load_src = data_ok_hit ? data_sram_rdata : rdata_q;

  mem_load_align u_load_align (
    .rdata       (load_src),
    .addr_lo     (addr_lo),
    .size        (ex_reg_q.mem_op.size),
    .is_unsigned (ex_reg_q.mem_op.is_unsigned),
    .load_data_c (load_data_c)
  );

  assign final_result = ex_reg_q.mem_op.is_load ? load_data_c : ex_reg_q.alu_result;

  assign wb_bus.gr_we        = ex_reg_q.gr_we;
  assign wb_bus.dest         = ex_reg_q.dest;
  assign wb_bus.final_result = final_result;
  assign wb_bus.pc           = ex_reg_q.pc;
  assign mem_reg             = wb_bus;

  assign fwd_bus.fwd_we        = mem_valid_q && ex_reg_q.gr_we;
  assign fwd_bus.fwd_load_busy = mem_valid_q && ex_reg_q.mem_op.is_load && !mem_ready_go;
  assign fwd_bus.dest          = ex_reg_q.dest;
  assign fwd_bus.result        = final_result;
  assign mem_fwd               = fwd_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized EX/WB/SRAM traffic,
// checked cycle by cycle against a transaction-level model of the MEM slot.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ex_to_mem_valid;
  logic [106:0] ex_reg;
  logic         mem_allowin;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [69:0]  mem_reg;
  logic [38:0]  mem_fwd;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [1:0]   data_sram_size;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .ex_reg            (ex_reg),
    .mem_allowin       (mem_allowin),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_reg           (mem_reg),
    .mem_fwd           (mem_fwd),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  typedef struct packed {
    bit        ld;
    bit        st;
    bit        uns;
    bit [1:0]  sz;
    bit        we;
    bit [4:0]  dest;
    bit [31:0] alu;
    bit [31:0] sd;
    bit [31:0] pc;
  } instr_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of the single MEM slot and the SRAM responder
  bit          slot_v;
  instr_t      slot;
  bit          slot_data;
  logic [31:0] slot_rd;
  int          slot_reqs;
  int          sram_phase;   // 0: no access outstanding, 2: waiting to return data
  int          a_wait, d_wait, force_a, force_d;
  instr_t      dir_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] res_log[$];
  bit          ex_idle, wb_force, prev_busy;
  int          wb_block, n_reqs, busy_rises;
  logic [31:0] last_res, last_addr, last_wdata;
  logic [4:0]  last_dest;
  logic [3:0]  last_strb;
  logic        last_we, last_wr;

  function automatic logic [106:0] pack(input instr_t i);
    return {i.ld, i.st, i.uns, i.sz, i.we, i.dest, i.alu, i.sd, i.pc};
  endfunction

  function automatic instr_t mk(input bit ld, input bit st, input bit uns, input bit [1:0] sz,
                                input bit we, input bit [4:0] dest, input bit [31:0] alu,
                                input bit [31:0] sd, input bit [31:0] pc);
    instr_t i;
    i.ld = ld; i.st = st; i.uns = uns; i.sz = sz; i.we = we;
    i.dest = dest; i.alu = alu; i.sd = sd; i.pc = pc;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int unsigned k = $urandom_range(0, 2);
    i.ld   = (k == 1);
    i.st   = (k == 2);
    i.uns  = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    i.sz   = (k == 0) ? 2'd0 : 2'($urandom_range(0, 2));
    i.we   = (k == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    i.dest = 5'($urandom());
    i.alu  = $urandom();
    i.sd   = $urandom();
    i.pc   = $urandom() & 32'hFFFF_FFFC;
    return i;
  endfunction

  // Loaded value by plain shift/mask arithmetic
  function automatic logic [31:0] exp_load(input instr_t i, input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    if (i.sz == 2'd0) begin
      sh = 8 * int'(i.alu[1:0]);
      v = (rd >> sh) & 32'h0000_00FF;
      if (!i.uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (i.sz == 2'd1) begin
      sh = 16 * int'(i.alu[1]);
      v = (rd >> sh) & 32'h0000_FFFF;
      if (!i.uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_strb(input instr_t i);
    if (!i.st) return 4'h0;
    if (i.sz == 2'd0) return 4'h1 << i.alu[1:0];
    if (i.sz == 2'd1) return i.alu[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input instr_t i);
    if (i.sz == 2'd0) return {24'd0, i.sd[7:0]} * 32'h0101_0101;
    if (i.sz == 2'd1) return {16'd0, i.sd[15:0]} * 32'h0001_0001;
    return i.sd;
  endfunction

  task automatic clear_model();
    slot_v = 0; slot_data = 0; slot_reqs = 0; sram_phase = 0; a_wait = 0; prev_busy = 0;
    rd_q.delete();
  endtask

  // One clock cycle: drive inputs at negedge, check at negedge+1, update model for the posedge
  task automatic step();
    instr_t nxt;
    bit exp_req, exp_vld, exp_allow, busy, dok, mem_op;
    logic [31:0] exp_res;
    @(negedge clk);
    nxt = (dir_q.size() > 0) ? dir_q[0] : rand_instr();
    ex_to_mem_valid = (dir_q.size() > 0) ? 1'b1 : (ex_idle ? 1'b0 : ($urandom_range(0, 3) != 0));
    ex_reg = pack(nxt);
    if (wb_block > 0) begin
      wb_allowin = 1'b0;
      wb_block--;
    end else begin
      wb_allowin = wb_force ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom();
    dok = 0;
    if (sram_phase == 2) begin
      if (d_wait == 0) begin
        data_sram_data_ok = 1'b1;
        if (rd_q.size() > 0) data_sram_rdata = rd_q.pop_front();
        dok = 1;
      end else begin
        d_wait--;
      end
    end else if (data_sram_req) begin
      if (a_wait == 0) data_sram_addr_ok = 1'b1;
      else a_wait--;
    end else if ($urandom_range(0, 7) == 0) begin
      data_sram_data_ok = 1'b1;   // stray response outside WAIT
    end
    #1;
    mem_op = slot.ld || slot.st;
    if (dok) slot_rd = data_sram_rdata;
    exp_res   = slot.ld ? exp_load(slot, slot_rd) : slot.alu;
    exp_req   = slot_v && mem_op && (slot_reqs == 0);
    exp_vld   = slot_v && (!mem_op || slot_data || dok);
    exp_allow = !slot_v || (exp_vld && wb_allowin);
    busy      = slot_v && slot.ld && !exp_vld;
    check("sram_req", data_sram_req, exp_req);
    check("to_wb_valid", mem_to_wb_valid, exp_vld);
    check("allowin", mem_allowin, exp_allow);
    check("fwd_we", mem_fwd[38], slot_v && slot.we);
    check("fwd_busy", mem_fwd[37], busy);
    if (slot_v) check("fwd_dest", mem_fwd[36:32], slot.dest);
    if (slot_v && !busy) check("fwd_result", mem_fwd[31:0], exp_res);
    if (exp_vld) check("mem_reg", mem_reg, {slot.we, slot.dest, exp_res, slot.pc});
    if (mem_fwd[37] && !prev_busy) busy_rises++;
    prev_busy = mem_fwd[37];
    if (data_sram_req && data_sram_addr_ok) begin
      check("req_addr", data_sram_addr, slot.alu);
      check("req_wr", data_sram_wr, slot.st);
      check("req_size", data_sram_size, slot.sz);
      check("req_wstrb", data_sram_wstrb, exp_strb(slot));
      if (slot.st) check("req_wdata", data_sram_wdata, exp_wdata(slot));
      last_addr = data_sram_addr; last_strb = data_sram_wstrb;
      last_wdata = data_sram_wdata; last_wr = data_sram_wr;
      slot_reqs++;
      n_reqs++;
      sram_phase = 2;
      d_wait = (force_d >= 0) ? force_d : $urandom_range(0, 3);
    end
    if (dok) begin
      slot_data  = 1;
      sram_phase = 0;
      a_wait = (force_a >= 0) ? force_a : $urandom_range(0, 2);
    end
    if (exp_allow) begin
      if (slot_v) begin
        check("reqs_per_instr", slot_reqs, mem_op ? 1 : 0);
        last_res = mem_reg[63:32]; last_we = mem_reg[69]; last_dest = mem_reg[68:64];
        res_log.push_back(mem_reg[63:32]);
      end
      slot_v = ex_to_mem_valid;
      if (ex_to_mem_valid) begin
        slot = nxt;
        if (dir_q.size() > 0) void'(dir_q.pop_front());
      end
      slot_data = 0;
      slot_reqs = 0;
    end
  endtask

  task automatic run_dir();
    int g = 0;
    while ((dir_q.size() > 0 || slot_v) && g < 200) begin
      step();
      g++;
    end
    check("drain_timeout", g >= 200, 0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; ex_to_mem_valid = 1'b0; wb_allowin = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic check_idle_outputs(input string tag);
    #1;
    check({tag, "_allowin"}, mem_allowin, 1);
    check({tag, "_to_wb"}, mem_to_wb_valid, 0);
    check({tag, "_req"}, data_sram_req, 0);
    check({tag, "_fwd"}, mem_fwd, 0);
  endtask

  // Reset while waiting for data, then a late data_ok that must be ignored
  task automatic reset_in_wait();
    int g = 0;
    ex_idle = 1; wb_force = 1; force_a = 1; force_d = 3; a_wait = 1;
    dir_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 5'd9, 32'h3000_0000, 32'd0, 32'h200));
    while (sram_phase != 2 && g < 50) begin
      step();
      g++;
    end
    check("wait_reached", sram_phase, 2);
    @(negedge clk);
    reset = 1'b1; ex_to_mem_valid = 1'b0; wb_allowin = 1'b1;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    @(negedge clk);
    reset = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    check_idle_outputs("rst_wait");
    check("rst_wait_mem_reg", mem_reg, 0);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    check_idle_outputs("rst_wait_after");
    clear_model();
  endtask

  initial begin
    reset = 1'b1; ex_to_mem_valid = 1'b0; ex_reg = '0; wb_allowin = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    ex_idle = 1; wb_force = 1; force_a = -1; force_d = -1; wb_block = 0;
    n_reqs = 0; busy_rises = 0; slot = '0; slot_rd = '0;
    clear_model();
    do_reset(3);
    check_idle_outputs("reset");
    check("reset_mem_reg", mem_reg, 0);
    check("reset_wr", data_sram_wr, 0);
    check("reset_wstrb", data_sram_wstrb, 0);
    check("reset_addr", data_sram_addr, 0);
    check("reset_wdata", data_sram_wdata, 0);
    check("reset_size", data_sram_size, 0);

    // ALU op passes straight through, no SRAM request
    n_reqs = 0;
    dir_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 5'd5, 32'h1234, 32'd0, 32'h100));
    run_dir();
    check("alu_result", last_res, 32'h1234);
    check("alu_we_dest", {last_we, last_dest}, {1'b1, 5'd5});
    check("alu_no_req", n_reqs, 0);

    // lb / lbu from the top byte lane
    a_wait = 2; force_d = 2;
    dir_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 5'd7, 32'h1000_0003, 32'd0, 32'h104));
    rd_q.push_back(32'h80FF_0000);
    run_dir();
    check("lb_result", last_res, 32'hFFFF_FF80);
    check("lb_addr", last_addr, 32'h1000_0003);
    a_wait = 2;
    dir_q.push_back(mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 5'd7, 32'h1000_0003, 32'd0, 32'h108));
    rd_q.push_back(32'h80FF_0000);
    run_dir();
    check("lbu_result", last_res, 32'h0000_0080);

    // sh to upper half
    force_d = -1;
    dir_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd3, 32'h2000_0002, 32'h0000_ABCD, 32'h10C));
    run_dir();
    check("sh_wstrb", last_strb, 4'b1100);
    check("sh_wdata", last_wdata, 32'hABCD_ABCD);
    check("sh_wr", last_wr, 1);
    check("sh_gr_we", last_we, 0);

    // lw whose data returns while WB is stalled
    wb_force = 0; force_a = 0; force_d = 0; a_wait = 0; wb_block = 8; n_reqs = 0;
    dir_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 5'd11, 32'h4000_0010, 32'd0, 32'h110));
    rd_q.push_back(32'hDEAD_BEEF);
    run_dir();
    check("lw_stall_result", last_res, 32'hDEAD_BEEF);
    check("lw_stall_reqs", n_reqs, 1);

    // Back-to-back lw, lw with zero-wait SRAM
    wb_force = 1; n_reqs = 0; busy_rises = 0; res_log.delete();
    dir_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 5'd12, 32'h5000_0000, 32'd0, 32'h114));
    dir_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 5'd13, 32'h5000_0004, 32'd0, 32'h118));
    rd_q.push_back(32'h1111_1111);
    rd_q.push_back(32'h2222_2222);
    run_dir();
    check("lwlw_reqs", n_reqs, 2);
    check("lwlw_busy_pulses", busy_rises, 2);
    check("lwlw_count", res_log.size(), 2);
    if (res_log.size() == 2) begin
      check("lwlw_first", res_log[0], 32'h1111_1111);
      check("lwlw_second", res_log[1], 32'h2222_2222);
    end

    // Randomized traffic
    ex_idle = 0; wb_force = 0; force_a = -1; force_d = -1;
    repeat (3000) step();
    ex_idle = 1;
    run_dir();

    reset_in_wait();

    // Stage must be usable again after the mid-transaction reset
    force_a = -1; force_d = -1;
    dir_q.push_back(mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 5'd20, 32'h6000_0002, 32'd0, 32'h300));
    rd_q.push_back(32'h9876_5432);
    run_dir();
    check("post_reset_lhu", last_res, 32'h0000_9876);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
